// File: rtl/axi_4_lite_slv_regfile.sv
// AXI4-Lite slave register file, parameterised in data width, address width
// and register count. AW and W are captured into independent one-entry holding
// registers and committed together once the B channel has room; reads run
// concurrently on their own channel. WR_PULSE/WR_INDEX announce each committed
// in-range write to user logic.
// Optional feature: define AXI4L_SLV_DECERR_EN to answer out-of-range accesses
// with SLVERR instead of OKAY.
module axi_4_lite_slv_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_COUNT  = 16,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH),
  localparam int IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [STRB_WIDTH-1:0] S_AXI_WSTRB,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  output logic [1:0]            S_AXI_BRESP,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  WR_PULSE,
  output logic [IDX_WIDTH-1:0]  WR_INDEX
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI4L_SLV_DECERR_EN
  localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif
  localparam logic [IDX_WIDTH:0] REG_LIMIT = REG_COUNT[IDX_WIDTH:0];

  logic                  alive;
  logic                  aw_full, w_full;
  logic [IDX_WIDTH-1:0]  aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0] w_data, rd_val;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic                  aw_in_range, ar_in_range;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // READYs stay low until the first edge after reset release.
  assign S_AXI_AWREADY = alive && !aw_full;
  assign S_AXI_WREADY  = alive && !w_full;
  assign S_AXI_ARREADY = alive && (!S_AXI_RVALID || S_AXI_RREADY);

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_full && w_full && (!S_AXI_BVALID || S_AXI_BREADY);

  assign ar_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign aw_in_range = {1'b0, aw_idx} < REG_LIMIT;
  assign ar_in_range = {1'b0, ar_idx} < REG_LIMIT;

  // Marks the slave as live one edge after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) alive <= 1'b0;
    else                alive <= 1'b1;
  end

  // AW and W holding registers; a commit empties both at once.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
    end
  end

  // Write response plus the user-side commit strobe.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      WR_PULSE     <= 1'b0;
      WR_INDEX     <= '0;
    end else begin
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= aw_in_range ? RESP_OKAY : RESP_OOR;
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
      WR_PULSE <= commit && aw_in_range;
      if (commit && aw_in_range) WR_INDEX <= aw_idx;
    end
  end

  // Register array, byte-lane write enables from the held strobe.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
    end else if (commit && aw_in_range) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (aw_idx == IDX_WIDTH'(r)) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (w_strb[b]) regs[r][8*b +: 8] <= w_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read mux; out-of-range indices fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      if (ar_idx == IDX_WIDTH'(r)) rd_val = regs[r];
    end
  end

  // Read response; data sampled pre-edge so a same-edge commit is not seen.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_val;
      S_AXI_RRESP  <= ar_in_range ? RESP_OKAY : RESP_OOR;
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_4_lite_slv_regfile.sv
// Bench for axi_4_lite_slv_regfile (default parameters): transaction-level
// reference model (queues + memory array) checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_axi_4_lite_slv_regfile;

`ifdef AXI4L_SLV_DECERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
  logic [7:0]  awaddr = 0, araddr = 0;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic [2:0]  awprot = 0, arprot = 0;
  logic awready, wready, arready, bvalid, rvalid, wr_pulse;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [5:0]  wr_index;

  int total = 0, bad = 0;

  axi_4_lite_slv_regfile dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .WR_PULSE(wr_pulse), .WR_INDEX(wr_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem [64];
  int          aw_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  bit          m_alive, m_bv, m_rv, m_pulse;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  int          m_pidx, b_done;
  bit          hs_aw, hs_w, hs_ar;

  initial begin
    int idx;
    logic [31:0] d;
    logic [3:0] s;
    bit awr, wr, arr, commit;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 64; i++) mem[i] = 0;
        aw_q.delete(); wd_q.delete(); ws_q.delete();
        m_alive = 0; m_bv = 0; m_rv = 0; m_pulse = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0; m_pidx = 0;
        hs_aw = 0; hs_w = 0; hs_ar = 0;
      end else begin
        awr = m_alive && aw_q.size() == 0;
        wr  = m_alive && wd_q.size() == 0;
        arr = m_alive && (!m_rv || rready);
        commit = aw_q.size() > 0 && wd_q.size() > 0 && (!m_bv || bready);
        hs_aw = awvalid && awr;
        hs_w  = wvalid && wr;
        hs_ar = arvalid && arr;
        if (hs_ar) begin
          idx = int'(araddr) / 4;
          m_rv = 1;
          m_rdata = (idx < 16) ? mem[idx] : 32'h0;
          m_rresp = (idx < 16) ? 2'b00 : OOR;
        end else if (rready) m_rv = 0;
        if (m_bv && bready) b_done++;
        if (commit) begin
          idx = aw_q.pop_front(); d = wd_q.pop_front(); s = ws_q.pop_front();
          if (idx < 16) begin
            for (int b = 0; b < 4; b++) if (s[b]) mem[idx][8*b +: 8] = d[8*b +: 8];
            m_pulse = 1; m_pidx = idx;
          end else m_pulse = 0;
          m_bv = 1;
          m_bresp = (idx < 16) ? 2'b00 : OOR;
        end else begin
          m_pulse = 0;
          if (bready) m_bv = 0;
        end
        if (hs_aw) aw_q.push_back(int'(awaddr) / 4);
        if (hs_w) begin wd_q.push_back(wdata); ws_q.push_back(wstrb); end
        m_alive = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("awready", awready, m_alive && aw_q.size() == 0);
    chk("wready",  wready,  m_alive && wd_q.size() == 0);
    chk("arready", arready, m_alive && (!m_rv || rready));
    chk("bvalid", bvalid, m_bv);
    if (m_bv) chk("bresp", bresp, m_bresp);
    chk("rvalid", rvalid, m_rv);
    if (m_rv) begin
      chk("rdata", rdata, m_rdata);
      chk("rresp", rresp, m_rresp);
    end
    chk("wr_pulse", wr_pulse, m_pulse);
    if (m_pulse) chk("wr_index", wr_index, m_pidx);
  end

  // ---------------- drivers (all aligned to posedge + #1) ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic timeout(input string nm);
    total++; bad++;
    $display("FAIL %s handshake timeout t=%0t", nm, $time);
  endtask

  task automatic send_aw(input logic [7:0] a);
    int n = 0;
    awvalid = 1; awaddr = a;
    do begin tick(1); n++; end while (!hs_aw && n < 60);
    if (!hs_aw) timeout("aw");
    awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wvalid = 1; wdata = d; wstrb = s;
    do begin tick(1); n++; end while (!hs_w && n < 60);
    if (!hs_w) timeout("w");
    wvalid = 0;
  endtask

  task automatic send_ar(input logic [7:0] a);
    int n = 0;
    arvalid = 1; araddr = a;
    do begin tick(1); n++; end while (!hs_ar && n < 60);
    if (!hs_ar) timeout("ar");
    arvalid = 0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    send_ar(a);
    d = rdata; r = rresp;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int b0;
    bit done;

    // Reset values.
    tick(2);
    chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0); chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_rdata", rdata, 0);
    chk("rst_pulse", wr_pulse, 0);
    rst_n = 1;
    tick(1);
    chk("rel_awready", awready, 1); chk("rel_arready", arready, 1);

    // Same-cycle AW/W to 0x04.
    fork send_aw(8'h04); send_w(32'hDEADBEEF, 4'hF); join
    chk("w1_bvalid_early", bvalid, 0);
    tick(1);
    chk("w1_bvalid", bvalid, 1); chk("w1_bresp", bresp, 0);
    chk("w1_pulse", wr_pulse, 1); chk("w1_index", wr_index, 1);
    tick(1);
    chk("w1_pulse_off", wr_pulse, 0);
    do_read(8'h04, d, r);
    chk("r1_data", d, 32'hDEADBEEF); chk("r1_resp", r, 0);

    // W ahead of AW, partial strobe.
    send_w(32'h11223344, 4'b0101);
    tick(2);
    chk("w2_no_commit", bvalid, 0); chk("w2_no_pulse", wr_pulse, 0);
    send_aw(8'h08);
    tick(2);
    do_read(8'h08, d, r);
    chk("r2_data", d, 32'h00220044);

    // Back-pressure on B.
    b0 = b_done;
    bready = 0;
    fork send_aw(8'h0C); send_w(32'hA5A5A5A5, 4'hF); join
    fork
      begin fork send_aw(8'h10); send_w(32'h5A5A5A5A, 4'hF); join end
      begin
        tick(3);
        chk("bp_awready", awready, 0); chk("bp_wready", wready, 0);
        chk("bp_bvalid", bvalid, 1);
        tick(2);
        bready = 1;
      end
    join
    tick(4);
    chk("bp_two_b", b_done - b0, 2);
    do_read(8'h0C, d, r); chk("bp_r0", d, 32'hA5A5A5A5);
    do_read(8'h10, d, r); chk("bp_r1", d, 32'h5A5A5A5A);

    // Back-to-back reads, then stall with RREADY low.
    arvalid = 1; araddr = 8'h00; tick(1);
    chk("burst0_v", rvalid, 1); chk("burst0", rdata, 32'h0); araddr = 8'h04; tick(1);
    chk("burst1_v", rvalid, 1); chk("burst1", rdata, 32'hDEADBEEF); araddr = 8'h08; tick(1);
    chk("burst2_v", rvalid, 1); chk("burst2", rdata, 32'h00220044);
    rready = 0; araddr = 8'h04; tick(2);
    chk("stall_data", rdata, 32'h00220044); chk("stall_arready", arready, 0);
    rready = 1; tick(1);
    chk("after_stall", rdata, 32'hDEADBEEF);
    arvalid = 0; tick(1);
    chk("burst_end", rvalid, 0);

    // Out-of-range index 16.
    fork send_aw(8'h40); send_w(32'hFFFFFFFF, 4'hF); join
    tick(1);
    chk("oor_bvalid", bvalid, 1); chk("oor_bresp", bresp, OOR); chk("oor_pulse", wr_pulse, 0);
    do_read(8'h40, d, r);
    chk("oor_rdata", d, 0); chk("oor_rresp", r, OOR);
    do_read(8'h00, d, r);
    chk("oor_reg0", d, 0);

    // Randomized concurrent traffic.
    done = 0;
    fork
      begin
        fork
          repeat (40) begin tick($urandom_range(0, 3)); send_aw(8'($urandom_range(0, 79))); end
          repeat (40) begin tick($urandom_range(0, 3)); send_w($urandom, 4'($urandom_range(0, 15))); end
          repeat (60) begin tick($urandom_range(0, 2)); send_ar(8'($urandom_range(0, 79))); end
        join
        done = 1;
      end
      while (!done) begin
        bready = $urandom_range(0, 3) != 0;
        rready = $urandom_range(0, 3) != 0;
        tick(1);
      end
    join
    bready = 1; rready = 1;
    tick(4);

    // Reset mid-write: AW held, W still pending.
    fork send_aw(8'h04); join
    #1 rst_n = 0;
    #1;
    chk("mid_awready", awready, 0); chk("mid_arready", arready, 0);
    chk("mid_bvalid", bvalid, 0);   chk("mid_rvalid", rvalid, 0);
    chk("mid_rdata", rdata, 0);     chk("mid_pulse", wr_pulse, 0);
    chk("mid_index", wr_index, 0);
    @(posedge clk); #3 rst_n = 1;
    tick(1);
    send_w(32'hCAFEF00D, 4'hF);
    tick(3);
    chk("post_bvalid", bvalid, 0);
    do_read(8'h04, d, r); chk("post_reg1", d, 0);
    do_read(8'h0C, d, r); chk("post_reg3", d, 0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
